// File: rtl/booth_prod_accumulator.sv
// Saturating signed multiply-accumulate back end for the 4x4 Booth multiplier stage.
// Sums a programmed number of products and returns the result over a valid/ready port.
module booth_prod_accumulator #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 12,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_terms,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned EXT_W = SUM_W - PROD_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_rem;
    logic               r_ovf;
    logic               r_prod_ready;
    logic               r_acc_valid;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_rem_nxt;
    logic               w_ovf_nxt;

    logic [SUM_W-1:0]   w_prod_ext;
    logic [SUM_W-1:0]   w_sum;
    logic               w_pos_ovf;
    logic               w_neg_ovf;
    logic [ACC_W-1:0]   w_sat;

    // One guard bit is enough: a single ACC_W + PROD_W add cannot wrap SUM_W bits.
    assign w_prod_ext = {{EXT_W{prod[PROD_W-1]}}, prod};
    assign w_sum      = {r_acc[ACC_W-1], r_acc} + w_prod_ext;
    assign w_pos_ovf  = ~w_sum[SUM_W-1] &  w_sum[SUM_W-2];
    assign w_neg_ovf  =  w_sum[SUM_W-1] & ~w_sum[SUM_W-2];

    always_comb begin
        w_sat = w_sum[ACC_W-1:0];
        if (w_pos_ovf) begin
            w_sat = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (w_neg_ovf) begin
            w_sat = {1'b1, {(ACC_W-1){1'b0}}};
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_rem;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_rem_nxt   = num_terms;
                    w_acc_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = (num_terms == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (prod_valid) begin
                    w_acc_nxt = w_sat;
                    w_ovf_nxt = r_ovf | w_pos_ovf | w_neg_ovf;
                    w_rem_nxt = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (acc_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they track r_state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_rem        <= '0;
            r_ovf        <= 1'b0;
            r_prod_ready <= 1'b0;
            r_acc_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_rem        <= w_rem_nxt;
            r_ovf        <= w_ovf_nxt;
            r_prod_ready <= (w_state_nxt == S_ACCUM);
            r_acc_valid  <= (w_state_nxt == S_DONE);
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign prod_ready = r_prod_ready;
    assign acc_out    = r_acc;
    assign acc_valid  = r_acc_valid;
    assign overflow   = r_ovf;
    assign busy       = r_busy;

endmodule

// File: tb/tb_booth_prod_accumulator.sv
// Directed self-checking bench for booth_prod_accumulator with hand-computed results.
`timescale 1ns/1ps
module tb_booth_prod_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_terms;
    logic [7:0]  prod;
    logic        prod_valid;
    logic        prod_ready;
    logic [11:0] acc_out;
    logic        acc_valid;
    logic        acc_ready;
    logic        overflow;
    logic        busy;

    int checks;
    int errors;
    logic [7:0] q[$];

    booth_prod_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_terms  (num_terms),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run with the products in q streamed back to back, then check and drain the result
    task automatic run(input string tag, input logic [11:0] exp_acc, input logic exp_ovf);
        start     = 1'b1;
        num_terms = 8'(q.size());
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_clr"}, 32'({acc_out, overflow}), 32'd0);
        for (int i = 0; i < q.size(); i++) begin
            chk({tag, "_rdy"}, 32'(prod_ready), 32'd1);
            prod_valid = 1'b1;
            prod       = q[i];
            tick();
        end
        prod_valid = 1'b0;
        chk({tag, "_valid"}, 32'(acc_valid), 32'd1);
        chk({tag, "_rdy_lo"}, 32'(prod_ready), 32'd0);
        chk({tag, "_acc"}, 32'(acc_out), 32'(exp_acc));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        chk({tag, "_idle"}, 32'({acc_valid, busy}), 32'd0);
        chk({tag, "_hold"}, 32'(acc_out), 32'(exp_acc));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        num_terms  = 8'd0;
        prod       = 8'd0;
        prod_valid = 1'b0;
        acc_ready  = 1'b0;
        #12;
        chk("reset", 32'({acc_out, acc_valid, prod_ready, overflow, busy}), 32'd0);
        rst_n = 1'b1;
        tick();

        q = {};
        for (int i = 0; i < 4; i++) q.push_back(8'h19);
        run("basic", 12'h064, 1'b0);

        q = {};
        q.push_back(8'hC8); q.push_back(8'h14); q.push_back(8'hF8);
        run("signed", 12'hFD4, 1'b0);

        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'h7F);
        run("satpos", 12'h7FF, 1'b1);

        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'h80);
        q.push_back(8'h40);
        run("satneg", 12'h840, 1'b1);

        // Backpressure with gaps, extra start pulses and a stalled consumer
        start = 1'b1; num_terms = 8'd2;
        tick();
        start = 1'b0;
        prod_valid = 1'b0;
        tick();
        chk("bp_gap", 32'(acc_out), 32'd0);
        prod_valid = 1'b1; prod = 8'h05;
        tick();
        chk("bp_acc1", 32'(acc_out), 32'h005);
        prod_valid = 1'b0; start = 1'b1; num_terms = 8'd9;
        tick();
        chk("bp_start_accum", 32'({prod_ready, acc_valid}), 32'b10);
        start = 1'b0; prod_valid = 1'b1; prod = 8'h03;
        tick();
        chk("bp_done", 32'({acc_valid, prod_ready}), 32'b10);
        prod = 8'h7F;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            chk("bp_stall_acc", 32'(acc_out), 32'h008);
            chk("bp_stall_vld", 32'({acc_valid, prod_ready, busy}), 32'b101);
        end
        prod_valid = 1'b0;
        // start during the handshake cycle is ignored, then taken a cycle later
        start = 1'b1; num_terms = 8'd0; acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        chk("hs_idle", 32'({acc_valid, busy}), 32'd0);
        chk("hs_hold", 32'(acc_out), 32'h008);
        tick();
        start = 1'b0;
        chk("zero_done", 32'({acc_valid, busy, prod_ready}), 32'b110);
        chk("zero_acc", 32'(acc_out), 32'd0);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        chk("zero_idle", 32'(busy), 32'd0);

        // Reset mid-ACCUM discards the partial sum
        start = 1'b1; num_terms = 8'd5;
        tick();
        start = 1'b0; prod_valid = 1'b1; prod = 8'h10;
        tick();
        tick();
        chk("mid_acc", 32'(acc_out), 32'h020);
        prod_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_reset", 32'({acc_out, acc_valid, prod_ready, overflow, busy}), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        q = {};
        q.push_back(8'h10);
        run("post_reset", 12'h010, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_prod_accumulator.md
# booth_prod_accumulator

Sequential multiply-accumulate back end that consumes the 8-bit signed products emitted by the combinational 4x4 Booth multiplier stage and sums a programmed number of them into a saturating signed accumulator. It sits directly downstream of the multiplier and presents a valid/ready result port to the next consumer. Typical use is dot products and FIR taps built from 4-bit signed operands.

## Interface
- PROD_W, 8: product width; matches the multiplier output `z`; two's complement.
- ACC_W, 12: accumulator width, signed; must be > PROD_W.
- CNT_W, 8: width of the term counter and `num_terms`.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new accumulation; sampled only in IDLE
- num_terms  input  CNT_W  products to accumulate; sampled with `start`
- prod  input  PROD_W  signed product from the multiplier
- prod_valid  input  1  `prod` is valid
- prod_ready  output  1  block accepts `prod` this cycle
- acc_out  output  ACC_W  signed accumulated result
- acc_valid  output  1  `acc_out` holds a final result
- acc_ready  input  1  consumer takes the result
- overflow  output  1  saturation occurred during the current or last run (sticky per run)
- busy  output  1  high in ACCUM or DONE

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: `prod_ready`=0, `acc_valid`=0, `busy`=0. On `start`=1:
  - Load remaining <= `num_terms`.
  - Clear `acc_out` and `overflow`.
  - Next state is DONE if `num_terms`=0, else ACCUM.
- ACCUM: `prod_ready`=1, `busy`=1.
  - A transfer happens when `prod_valid` & `prod_ready`. On a transfer:
    - acc <= sat(acc + sign_extend(prod)).
    - remaining <= remaining - 1.
    - If remaining = 1, next state is DONE.
  - Cycles with no transfer leave all state unchanged.
- DONE: `prod_ready`=0, `acc_valid`=1, `busy`=1. `acc_out` and `overflow` are held stable.
  - On `acc_ready`=1, next state is IDLE.
  - After leaving DONE, `acc_out` and `overflow` hold their values until the next `start`.
- `start` is ignored in ACCUM and DONE. There is no abort except `rst_n`.
- Arithmetic:
  - Compute the sum at ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1: clamp to max (12'h7FF) and set `overflow`.
  - Below -2^(ACC_W-1): clamp to min (12'h800) and set `overflow`.
  - Accumulation continues from the clamped value. Later terms can pull the result back in range, but `overflow` stays set.
- Reset (`rst_n`=0, asynchronous, at any time including mid-ACCUM):
  - State goes to IDLE.
  - `acc_out`=0, `acc_valid`=0, `prod_ready`=0, `overflow`=0, `busy`=0, remaining=0.
  - Any partial sum is discarded.

## Timing
- `start` sampled at rising edge T. `busy`=1 and `prod_ready`=1 from T+1, or DONE at T+1 if `num_terms`=0.
- Each product is accepted on the edge where `prod_valid` & `prod_ready` are both high; `acc_out` updates at that edge.
- Throughput is one product per cycle with `prod_valid` held high. N terms with no stalls take N cycles in ACCUM.
- The last accepting edge moves the FSM to DONE, so `acc_valid`=1 in the following cycle. Latency from the last product to result is 1 cycle.
- `prod_ready` drops in the same cycle the FSM enters DONE. No product is accepted beyond `num_terms`.
- Result handshake completes on the edge with `acc_valid` & `acc_ready`. `acc_valid` is 0 the next cycle.
- Back-to-back runs: IDLE lasts at least 1 cycle. `start` asserted during the handshake cycle is ignored; it is taken the next cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Basic: `start`, `num_terms`=4, products 0x19 ×4 (5×5) streamed back-to-back.
  -> `acc_out`=12'h064 (100), `acc_valid` one cycle after the 4th accept, `overflow`=0.
- Signed: `num_terms`=3, products 0xC8 (-56), 0x14 (+20), 0xF8 (-8).
  -> `acc_out`=12'hFD4 (-44), `overflow`=0.
- Saturation, positive: `num_terms`=20, all 0x7F. -> `acc_out`=12'h7FF, `overflow`=1.
- Saturation, negative then recovery: `num_terms`=21, twenty × 0x80 then one 0x40. -> `acc_out`=12'h840 (-1984), `overflow`=1.
- Backpressure/ignore:
  - Stimulus: `prod_valid` toggling with gaps, `num_terms`=2, `acc_ready` held low 5 cycles in DONE, `start` pulsed during ACCUM and DONE.
  - Required: only 2 products accepted, `acc_out` stable while `acc_valid`=1, extra `start` pulses have no effect.
- Zero terms and reset:
  - `num_terms`=0 -> DONE at T+1 with `acc_out`=0.
  - Then a new run: `num_terms`=5, `rst_n` pulsed low after 2 accepts -> all outputs 0 immediately.
  - A subsequent `start`, `num_terms`=1, product 0x10 -> `acc_out`=12'h010.
